keypad_entry: RTL and testbench

Reads a 4x4 matrix keypad by row scanning and builds a decimal number of up to four digits for the single-cycle processor. It is the input-side companion of the multiplexed 4-digit seven-segment display driver. It runs on `clk_100mhz` and debounces every key press and release. It exposes a live entry value for echo on the display, plus a committed value with a one-cycle valid pulse that the processor side captures.

---
 rtl/keypad_entry_pkg.sv | 41 ++++
 rtl/keypad_entry_scanner.sv | 96 +++++++++
 rtl/keypad_entry.sv | 75 +++++++
 tb/tb_keypad_entry.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared key codes, scanner FSM state encoding and key-map helpers
// for the matrix keypad entry block.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [1:0] ST_SCAN        = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

  // Physical layout: rows top to bottom, columns left to right.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;     4'h1: code = 4'd2;     4'h2: code = 4'd3;     4'h3: code = KEY_A;
      4'h4: code = 4'd4;     4'h5: code = 4'd5;     4'h6: code = 4'd6;     4'h7: code = KEY_B;
      4'h8: code = 4'd7;     4'h9: code = 4'd8;     4'hA: code = 4'd9;     4'hB: code = KEY_C;
      4'hC: code = KEY_STAR; 4'hD: code = 4'd0;     4'hE: code = KEY_HASH; default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Index of the single set bit of a one-hot column mask.
  function automatic logic [1:0] col_index(input logic [3:0] onehot);
    logic [1:0] idx;
    case (onehot)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_scanner.sv
// Row scanner with column synchronizer, sample divider and press/release
// debounce; emits a one-cycle strobe and code per accepted key.
module keypad_scanner
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

  logic [3:0]       r_col_meta, r_col_sync, r_lat_col;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row, r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_code;

  logic             w_tick, w_none, w_one;
  logic [3:0]       w_low;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_tick     = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_low      = ~r_col_sync;
  assign w_none     = (w_low == 4'd0);
  assign w_one      = !w_none && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_cnt_next = r_cnt + 1'b1;

  assign row_out    = ~(4'b0001 << r_row);
  assign key_strobe = (r_state == ST_PRESSED);
  assign key_code   = r_code;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_lat_col  <= 4'hF;
      r_div      <= '0;
      r_row      <= 2'd0;
      r_state    <= ST_SCAN;
      r_cnt      <= '0;
      r_code     <= 4'd0;
    end else begin
      r_col_meta <= col_in;
      r_col_sync <= r_col_meta;
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      case (r_state)
        ST_SCAN: if (w_tick) begin
          // Multi-key samples are treated like an idle row and skipped.
          if (w_one) begin
            r_lat_col <= r_col_sync;
            r_cnt     <= '0;
            r_state   <= ST_DEB_PRESS;
          end else begin
            r_row <= r_row + 2'd1;
          end
        end
        ST_DEB_PRESS: if (w_tick) begin
          if (r_col_sync == r_lat_col) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == CNT_W'(DEBOUNCE_N)) begin
              r_state <= ST_PRESSED;
              r_code  <= key_lookup(r_row, col_index(~r_lat_col));
            end
          end else begin
            r_state <= ST_SCAN;
            r_row   <= r_row + 2'd1;
          end
        end
        ST_PRESSED: begin
          r_cnt   <= '0;
          r_state <= ST_DEB_RELEASE;
        end
        default: if (w_tick) begin
          if (w_none) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == CNT_W'(DEBOUNCE_N)) begin
              r_state <= ST_SCAN;
              r_row   <= r_row + 2'd1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: up to four decimal digits, '*' clears, '#' commits
// the accumulated value with a one-cycle valid pulse.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] accum_value,
  output logic [2:0]  digit_count,
  output logic [15:0] entered_value,
  output logic        value_valid
);

  logic        w_strobe, w_is_digit;
  logic [3:0]  w_code;
  logic [15:0] r_accum, r_entered;
  logic [2:0]  r_count;
  logic        r_valid;

  keypad_scanner #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_scanner (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_strobe (w_strobe),
    .key_code   (w_code)
  );

  assign w_is_digit    = (w_code <= 4'd9);
  assign key_strobe    = w_strobe;
  assign key_code      = w_code;
  assign accum_value   = r_accum;
  assign digit_count   = r_count;
  assign entered_value = r_entered;
  assign value_valid   = r_valid;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      r_accum   <= 16'd0;
      r_count   <= 3'd0;
      r_entered <= 16'd0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_strobe) begin
        // x*10 as shift-add; four digits cap the value at 9999.
        if (w_is_digit) begin
          if (r_count < 3'd4) begin
            r_accum <= (r_accum << 3) + (r_accum << 1) + {12'd0, w_code};
            r_count <= r_count + 3'd1;
          end
        end else if (w_code == KEY_STAR) begin
          r_accum <= 16'd0;
          r_count <= 3'd0;
        end else if (w_code == KEY_HASH) begin
          r_entered <= r_accum;
          r_valid   <= 1'b1;
          r_accum   <= 16'd0;
          r_count   <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench: behavioural keypad drives col_in from row_out; a
// decimal-arithmetic model predicts the entry outputs after each strobe.
module tb_keypad_entry;

  logic        clk_100mhz = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] accum_value;
  logic [2:0]  digit_count;
  logic [15:0] entered_value;
  logic        value_valid;

  keypad_entry #(.SCAN_DIV(8), .DEBOUNCE_N(3)) dut (
    .clk_100mhz    (clk_100mhz),
    .reset         (reset),
    .col_in        (col_in),
    .row_out       (row_out),
    .key_strobe    (key_strobe),
    .key_code      (key_code),
    .accum_value   (accum_value),
    .digit_count   (digit_count),
    .entered_value (entered_value),
    .value_valid   (value_valid)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Key layout, index = row*4 + col.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
  logic [15:0] held = 16'd0;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  int errors = 0, checks = 0;
  int strobe_cnt = 0;
  bit bad_row = 0;
  int macc = 0, mcnt = 0, ment = 0;

  always @(negedge clk_100mhz) begin
    if (!reset && key_strobe) strobe_cnt++;
    if ($countones(row_out) != 3) bad_row = 1;
  end

  task automatic model_apply(input logic [3:0] code, output bit exp_valid);
    exp_valid = 0;
    if (code <= 4'd9) begin
      if (mcnt < 4) begin macc = macc * 10 + int'(code); mcnt++; end
    end else if (code == 4'hE) begin
      macc = 0; mcnt = 0;
    end else if (code == 4'hF) begin
      ment = macc; exp_valid = 1; macc = 0; mcnt = 0;
    end
  endtask

  task automatic press_code(input logic [3:0] code, input int extra);
    int idx, base;
    bit got, ev;
    idx = 0;
    for (int i = 0; i < 16; i++) if (keymap[i] == code) idx = i;
    base = strobe_cnt;
    got = 0;
    held[idx] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_100mhz);
      if (key_strobe) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL strobe_timeout key=%h got=0 expected=1", code);
      held = 16'd0;
      repeat (60) @(negedge clk_100mhz);
      return;
    end
    checks++;
    if (key_code !== code) begin
      errors++; $display("FAIL key_code got=%h expected=%h", key_code, code);
    end
    checks++;
    if (accum_value !== 16'(macc) || digit_count !== 3'(mcnt)) begin
      errors++; $display("FAIL early_update accum=%0d cnt=%0d expected %0d/%0d", accum_value, digit_count, macc, mcnt);
    end
    model_apply(code, ev);
    @(negedge clk_100mhz);
    checks++;
    if (key_strobe !== 1'b0) begin
      errors++; $display("FAIL strobe_width got=%b expected=0", key_strobe);
    end
    checks++;
    if (accum_value !== 16'(macc) || digit_count !== 3'(mcnt)) begin
      errors++; $display("FAIL accum key=%h got=%0d/%0d expected=%0d/%0d", code, accum_value, digit_count, macc, mcnt);
    end
    checks++;
    if (entered_value !== 16'(ment) || value_valid !== ev) begin
      errors++; $display("FAIL entered key=%h got=%0d/%b expected=%0d/%b", code, entered_value, value_valid, ment, ev);
    end
    @(negedge clk_100mhz);
    checks++;
    if (value_valid !== 1'b0) begin
      errors++; $display("FAIL valid_width got=%b expected=0", value_valid);
    end
    repeat (extra) @(negedge clk_100mhz);
    held[idx] = 1'b0;
    repeat (48) @(negedge clk_100mhz);
    checks++;
    if (strobe_cnt != base + 1) begin
      errors++; $display("FAIL strobe_count key=%h got=%0d expected=1", code, strobe_cnt - base);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (row_out !== 4'b1110 || key_strobe !== 1'b0 || key_code !== 4'd0 || accum_value !== 16'd0 ||
        digit_count !== 3'd0 || entered_value !== 16'd0 || value_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s row=%b stb=%b code=%h acc=%0d cnt=%0d ent=%0d vld=%b expected 1110/0/0/0/0/0/0",
               tag, row_out, key_strobe, key_code, accum_value, digit_count, entered_value, value_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    check_reset_values("reset_values");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    press_code(4'h1, 0); press_code(4'h2, 5); press_code(4'h3, 0); press_code(4'h4, 10);
    press_code(4'hF, 0);
    checks++;
    if (entered_value !== 16'd1234 || accum_value !== 16'd0 || digit_count !== 3'd0) begin
      errors++; $display("FAIL basic_commit got=%0d/%0d/%0d expected=1234/0/0", entered_value, accum_value, digit_count);
    end
  endtask

  task automatic test_fifth_digit();
    for (int i = 0; i < 4; i++) press_code(4'h9, 3);
    press_code(4'h7, 0);
    checks++;
    if (accum_value !== 16'd9999) begin
      errors++; $display("FAIL fifth_digit got=%0d expected=9999", accum_value);
    end
    press_code(4'hF, 0);
    checks++;
    if (entered_value !== 16'd9999) begin
      errors++; $display("FAIL fifth_commit got=%0d expected=9999", entered_value);
    end
  endtask

  task automatic test_clear();
    press_code(4'h5, 0); press_code(4'h6, 0); press_code(4'hE, 0);
    checks++;
    if (accum_value !== 16'd0 || entered_value !== 16'd9999) begin
      errors++; $display("FAIL clear got=%0d/%0d expected=0/9999", accum_value, entered_value);
    end
    press_code(4'h8, 0); press_code(4'hF, 0);
    checks++;
    if (entered_value !== 16'd8) begin
      errors++; $display("FAIL clear_commit got=%0d expected=8", entered_value);
    end
    press_code(4'hF, 0);
    checks++;
    if (entered_value !== 16'd0) begin
      errors++; $display("FAIL empty_commit got=%0d expected=0", entered_value);
    end
  endtask

  task automatic test_bounce();
    int base;
    base = strobe_cnt;
    // 16 low / 8 high cycles: never more than two consecutive low samples.
    for (int i = 0; i < 20; i++) begin
      held[5] = 1'b1; repeat (16) @(negedge clk_100mhz);
      held[5] = 1'b0; repeat (8) @(negedge clk_100mhz);
    end
    repeat (48) @(negedge clk_100mhz);
    checks++;
    if (strobe_cnt != base) begin
      errors++; $display("FAIL bounce_strobe got=%0d expected=0", strobe_cnt - base);
    end
    press_code(4'h5, 400);
  endtask

  task automatic test_multi_key();
    int base;
    logic [3:0] seen;
    base = strobe_cnt;
    seen = 4'd0;
    held[1] = 1'b1; held[2] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_100mhz);
      seen = seen | ~row_out;
    end
    held = 16'd0;
    repeat (48) @(negedge clk_100mhz);
    checks++;
    if (strobe_cnt != base) begin
      errors++; $display("FAIL multi_strobe got=%0d expected=0", strobe_cnt - base);
    end
    checks++;
    if (seen !== 4'hF) begin
      errors++; $display("FAIL multi_scan rows_seen=%b expected=1111", seen);
    end
    base = macc;
    press_code(4'hD, 0);
    checks++;
    if (accum_value !== 16'(base)) begin
      errors++; $display("FAIL letter_no_effect got=%0d expected=%0d", accum_value, base);
    end
  endtask

  task automatic test_random();
    logic [3:0] pool [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};
    for (int i = 0; i < 16; i++)
      press_code(pool[$urandom_range(11, 0)], int'($urandom_range(20, 0)));
  endtask

  task automatic test_reset_mid();
    int base;
    bit found;
    press_code(4'h3, 0);
    base = strobe_cnt;
    found = 0;
    held[5] = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_100mhz);
      if (row_out == 4'b1101) found = 1;
    end
    repeat (12) @(negedge clk_100mhz);
    checks++;
    if (row_out !== 4'b1101) begin
      errors++; $display("FAIL deb_press_frozen row=%b expected=1101", row_out);
    end
    reset = 1'b1;
    @(negedge clk_100mhz);
    check_reset_values("reset_mid");
    held = 16'd0;
    repeat (2) @(negedge clk_100mhz);
    reset = 1'b0;
    macc = 0; mcnt = 0; ment = 0;
    repeat (100) @(negedge clk_100mhz);
    checks++;
    if (strobe_cnt != base || accum_value !== 16'd0) begin
      errors++; $display("FAIL reset_mid_strobe strobes=%0d acc=%0d expected=0/0", strobe_cnt - base, accum_value);
    end
    press_code(4'h7, 0);
  endtask

  task automatic test_row_onehot();
    checks++;
    if (bad_row) begin
      errors++; $display("FAIL row_onehot got=1 expected=0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifth_digit();
    test_clear();
    test_bounce();
    test_multi_key();
    test_random();
    test_reset_mid();
    test_row_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
